// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - front-end halt/bubble/flush sequencing for load-use, memory wait and taken branches
module pipeline_hazard_ctrl #(
  parameter int SYS_REGS_WIDTH = 5,
  parameter int LOAD_LAT       = 2,
  parameter int FLUSH_CYCLES   = 2,
  parameter int MEM_TIMEOUT    = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SYS_REGS_WIDTH-1:0] i_id_rs1_addr,
  input  logic [SYS_REGS_WIDTH-1:0] i_id_rs2_addr,
  input  logic                      i_id_rs1_used,
  input  logic                      i_id_rs2_used,
  input  logic [SYS_REGS_WIDTH-1:0] i_of_rd_addr,
  input  logic                      i_of_rd_we,
  input  logic                      i_of_is_load,
  input  logic                      i_mem_req,
  input  logic                      i_mem_ack,
  input  logic                      i_branch_taken,
  output logic                      o_halt_fetch,
  output logic                      o_halt_decode,
  output logic                      o_halt_of,
  output logic                      o_bubble_of,
  output logic                      o_flush,
  output logic                      o_mem_err,
  output logic [31:0]               o_stall_count,
  output logic [1:0]                o_state_out
);

  localparam int CNT_W  = 8;
  localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;

  localparam logic [CNT_W-1:0]  LOAD_INIT  = CNT_W'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0]  FLUSH_INIT = CNT_W'(FLUSH_CYCLES - 1);
  // Compare against MEM_TIMEOUT-1 so the entry cycle plus MEM_WAIT cycles total MEM_TIMEOUT halted cycles.
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2,
    FLUSH      = 2'd3
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WAIT_W-1:0]  r_wait_cnt;
  logic [31:0]        r_stall_count;

  state_t             w_next_state;
  logic [CNT_W-1:0]   w_next_cnt;
  logic [WAIT_W-1:0]  w_next_wait;
  logic               w_halt_fd;
  logic               w_halt_of;
  logic               w_bubble;
  logic               w_flush;
  logic               w_err;
  logic               w_load_use;
  logic               w_rs1_hit;
  logic               w_rs2_hit;

  assign w_rs1_hit  = i_id_rs1_used && (i_id_rs1_addr == i_of_rd_addr);
  assign w_rs2_hit  = i_id_rs2_used && (i_id_rs2_addr == i_of_rd_addr);
  assign w_load_use = i_of_is_load && i_of_rd_we && (i_of_rd_addr != '0) && (w_rs1_hit || w_rs2_hit);

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_wait  = r_wait_cnt;
    w_halt_fd    = 1'b0;
    w_halt_of    = 1'b0;
    w_bubble     = 1'b0;
    w_flush      = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      RUN: begin
        if (i_branch_taken) begin
          w_flush      = 1'b1;
          w_bubble     = 1'b1;
          w_next_cnt   = FLUSH_INIT;
          w_next_state = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
        end else if (i_mem_req && !i_mem_ack) begin
          w_halt_fd    = 1'b1;
          w_halt_of    = 1'b1;
          w_next_wait  = '0;
          w_next_state = MEM_WAIT;
        end else if (w_load_use) begin
          w_halt_fd    = 1'b1;
          w_bubble     = 1'b1;
          w_next_cnt   = LOAD_INIT;
          w_next_state = (LOAD_LAT == 1) ? RUN : LOAD_STALL;
        end
      end
      LOAD_STALL: begin
        if (i_branch_taken) begin
          w_flush      = 1'b1;
          w_bubble     = 1'b1;
          w_next_cnt   = FLUSH_INIT;
          w_next_state = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
        end else begin
          w_halt_fd  = 1'b1;
          w_bubble   = 1'b1;
          w_next_cnt = r_cnt - 1'b1;
          if (r_cnt <= 1) begin
            w_next_state = RUN;
          end
        end
      end
      MEM_WAIT: begin
        if (i_mem_ack) begin
          w_next_state = RUN;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_err        = 1'b1;
          w_next_state = RUN;
        end else begin
          w_halt_fd   = 1'b1;
          w_halt_of   = 1'b1;
          w_next_wait = r_wait_cnt + 1'b1;
        end
      end
      FLUSH: begin
        w_flush    = 1'b1;
        w_bubble   = 1'b1;
        w_next_cnt = r_cnt - 1'b1;
        if (r_cnt <= 1) begin
          w_next_state = RUN;
        end
      end
      default: begin
        w_next_state = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= RUN;
      r_cnt         <= '0;
      r_wait_cnt    <= '0;
      r_stall_count <= '0;
    end else begin
      r_state    <= w_next_state;
      r_cnt      <= w_next_cnt;
      r_wait_cnt <= w_next_wait;
      if (w_halt_fd && (r_stall_count != 32'hFFFF_FFFF)) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
    end
  end

  // Reset forces every output low, including the registered ones still holding pre-reset values.
  assign o_halt_fetch  = rst_n && w_halt_fd;
  assign o_halt_decode = rst_n && w_halt_fd;
  assign o_halt_of     = rst_n && w_halt_of;
  assign o_bubble_of   = rst_n && w_bubble && !w_halt_of;
  assign o_flush       = rst_n && w_flush;
  assign o_mem_err     = rst_n && w_err;
  assign o_stall_count = rst_n ? r_stall_count : 32'd0;
  assign o_state_out   = rst_n ? r_state : RUN;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl with a behavioural hazard model
module tb_pipeline_hazard_ctrl;

  localparam int LL = 2;
  localparam int FC = 2;
  localparam int MT = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1_addr, id_rs2_addr, of_rd_addr;
  logic        id_rs1_used, id_rs2_used, of_rd_we, of_is_load;
  logic        mem_req, mem_ack, branch_taken;
  logic        halt_fetch, halt_decode, halt_of, bubble_of, flush, mem_err;
  logic [31:0] stall_count;
  logic [1:0]  state_out;

  typedef struct packed {
    logic       hf;
    logic       hd;
    logic       ho;
    logic       bo;
    logic       fl;
    logic       er;
    logic [1:0] st;
    logic [31:0] sc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Behavioural model: remaining-cycle counters rather than a state machine.
  int    m_stall_left = 0;
  int    m_flush_left = 0;
  bit    m_mem_active = 0;
  int    m_mem_halted = 0;
  longint m_stalls    = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .SYS_REGS_WIDTH(5), .LOAD_LAT(LL), .FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_id_rs1_addr(id_rs1_addr), .i_id_rs2_addr(id_rs2_addr),
    .i_id_rs1_used(id_rs1_used), .i_id_rs2_used(id_rs2_used),
    .i_of_rd_addr(of_rd_addr), .i_of_rd_we(of_rd_we), .i_of_is_load(of_is_load),
    .i_mem_req(mem_req), .i_mem_ack(mem_ack), .i_branch_taken(branch_taken),
    .o_halt_fetch(halt_fetch), .o_halt_decode(halt_decode), .o_halt_of(halt_of),
    .o_bubble_of(bubble_of), .o_flush(flush), .o_mem_err(mem_err),
    .o_stall_count(stall_count), .o_state_out(state_out)
  );

  function automatic exp_t model_step();
    exp_t e;
    bit   lu;
    e = '0;
    if (!rst_n) begin
      m_stall_left = 0; m_flush_left = 0; m_mem_active = 0; m_mem_halted = 0; m_stalls = 0;
      return e;
    end
    lu = of_is_load && of_rd_we && (of_rd_addr != 0) &&
         ((id_rs1_used && id_rs1_addr == of_rd_addr) || (id_rs2_used && id_rs2_addr == of_rd_addr));
    e.sc = 32'(m_stalls);
    if (m_flush_left > 0)      e.st = 2'd3;
    else if (m_mem_active)     e.st = 2'd2;
    else if (m_stall_left > 0) e.st = 2'd1;
    else                       e.st = 2'd0;

    if (m_flush_left > 0) begin
      e.fl = 1; e.bo = 1; m_flush_left--;
    end else if (m_mem_active) begin
      if (mem_ack) m_mem_active = 0;
      else if (m_mem_halted == MT) begin e.er = 1; m_mem_active = 0; end
      else begin e.hf = 1; e.hd = 1; e.ho = 1; m_mem_halted++; end
    end else if (branch_taken) begin
      e.fl = 1; e.bo = 1; m_flush_left = FC - 1; m_stall_left = 0;
    end else if (m_stall_left > 0) begin
      e.hf = 1; e.hd = 1; e.bo = 1; m_stall_left--;
    end else if (mem_req && !mem_ack) begin
      e.hf = 1; e.hd = 1; e.ho = 1; m_mem_active = 1; m_mem_halted = 1;
    end else if (lu) begin
      e.hf = 1; e.hd = 1; e.bo = 1; m_stall_left = LL - 1;
    end
    if (e.hf) m_stalls++;
    return e;
  endfunction

  task automatic drive(input logic rstn, input logic br, input logic mreq, input logic mack,
                       input logic ld, input logic we, input logic [4:0] rd,
                       input logic [4:0] a1, input logic u1, input logic [4:0] a2, input logic u2);
    @(posedge clk);
    #1;
    rst_n = rstn; branch_taken = br; mem_req = mreq; mem_ack = mack;
    of_is_load = ld; of_rd_we = we; of_rd_addr = rd;
    id_rs1_addr = a1; id_rs1_used = u1; id_rs2_addr = a2; id_rs2_used = u2;
    exp_q.push_back(model_step());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    exp_t g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = '{hf: halt_fetch, hd: halt_decode, ho: halt_of, bo: bubble_of,
            fl: flush, er: mem_err, st: state_out, sc: stall_count};
      n_checks++;
      if (g[39:32] === e[39:32]) n_pass++;
      else $display("FAIL controls at %0t: got hf%b hd%b ho%b bo%b fl%b er%b st%0d, expected hf%b hd%b ho%b bo%b fl%b er%b st%0d",
                    $time, g.hf, g.hd, g.ho, g.bo, g.fl, g.er, g.st, e.hf, e.hd, e.ho, e.bo, e.fl, e.er, e.st);
      n_checks++;
      if (g.sc === e.sc) n_pass++;
      else $display("FAIL stall_count at %0t: got %0d expected %0d", $time, g.sc, e.sc);
    end
  end

  initial begin
    rst_n = 0; branch_taken = 0; mem_req = 0; mem_ack = 0; of_is_load = 0; of_rd_we = 0;
    of_rd_addr = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_used = 0; id_rs2_used = 0;
    drive(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    drive(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    idle(2);
    // load-use on rs1, held for the stall window
    repeat (3) drive(1, 0, 0, 0, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0);
    idle(1);
    // non-hazards: rd=0, rs1 not used
    repeat (2) drive(1, 0, 0, 0, 1, 1, 5'd0, 5'd0, 1, 5'd0, 0);
    repeat (2) drive(1, 0, 0, 0, 1, 1, 5'd5, 5'd5, 0, 5'd0, 0);
    // branch together with load-use
    drive(1, 1, 0, 0, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0);
    repeat (2) drive(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    // memory wait of 3 then ack
    repeat (3) drive(1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    drive(1, 0, 1, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    idle(1);
    // memory timeout
    repeat (17) drive(1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    idle(1);
    // reset in the middle of MEM_WAIT
    repeat (2) drive(1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    drive(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    idle(2);
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 599) != 0), ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1),
            5'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1));
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
